// File: rtl/ahb_apb_pkg.sv
// Shared encodings and defaults for the AHB-Lite to APB bridge controller.
package ahb_apb_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Bridge FSM states, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WWAIT  = 2'd1;
    localparam state_t ST_SETUP  = 2'd2;
    localparam state_t ST_ENABLE = 2'd3;

    // Default APB region map: three 64 MB windows starting at 0x8000_0000
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam int          DEF_NSLV      = 3;
    localparam int          DEF_SPAN_BITS = 26;

    // The bridge never signals an error
    localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational AHB address-phase decode: qualifies the transfer and picks
// the one-hot APB slave select for the addressed window.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int                NSLV      = DEF_NSLV,
    parameter int                SPAN_BITS = DEF_SPAN_BITS
) (
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hreadyin,
    output logic              valid,
    output logic [NSLV-1:0]   sel
);

    // Total size of the bridged region; one extra bit so the bound cannot wrap
    localparam logic [ADDR_W:0] REGION_SIZE = (ADDR_W+1)'(NSLV) << SPAN_BITS;

    logic [ADDR_W:0] offset;
    logic            in_range;
    logic            active;

    // The extra top bit of the offset is the borrow: set when haddr < BASE_ADDR
    assign offset   = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign in_range = !offset[ADDR_W] && (offset < REGION_SIZE);
    assign active   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign valid    = hreadyin && active && in_range;

    // One-hot select from the window index (offset >> SPAN_BITS)
    always_comb begin
        // NOTE: every bit of sel gets a default before the loop so no path leaves it unassigned (no latch).
        sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel[i] = valid && (offset[ADDR_W-1:SPAN_BITS] == (ADDR_W-SPAN_BITS)'(i));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-Lite slave / APB master controller. Accepts an address phase whenever
// hreadyout is high, then runs WWAIT (writes only), SETUP and ENABLE.
// APB outputs come only from registered state.
module ahb_apb_bridge_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int                NSLV      = DEF_NSLV,
    parameter int                SPAN_BITS = DEF_SPAN_BITS
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic              hreadyin,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata,
    output logic [1:0]        hresp,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [NSLV-1:0]   pselx,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata
);

    state_t            state;
    state_t            state_nxt;
    logic              valid;
    logic [NSLV-1:0]   sel;
    logic              accept;
    logic [ADDR_W-1:0] addr_r;
    logic              write_r;
    logic [NSLV-1:0]   sel_r;

    ahb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .NSLV      (NSLV),
        .SPAN_BITS (SPAN_BITS)
    ) u_decode (
        .haddr    (haddr),
        .htrans   (htrans),
        .hreadyin (hreadyin),
        .valid    (valid),
        .sel      (sel)
    );

    // An address phase is taken only in cycles where we signal ready
    assign accept = valid && hreadyout;

    // Next-state: IDLE and ENABLE both accept a new transfer, giving back-to-back access
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ENABLE: begin
                if (valid) begin
                    state_nxt = hwrite ? ST_WWAIT : ST_SETUP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WWAIT: state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_ENABLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register plus latched address phase
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= ST_IDLE;
            addr_r  <= '0;
            write_r <= 1'b0;
            sel_r   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (accept) begin
                addr_r  <= haddr;
                write_r <= hwrite;
                sel_r   <= sel;
            end
        end
    end

    // Write data is captured in WWAIT, where the master holds hwdata valid
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pwdata <= '0;
        end else if (state == ST_WWAIT) begin
            pwdata <= hwdata;
        end
    end

    // Outputs decoded from registered state only
    assign hreadyout = (state == ST_IDLE) || (state == ST_ENABLE);
    assign pselx     = ((state == ST_SETUP) || (state == ST_ENABLE)) ? sel_r : '0;
    assign penable   = (state == ST_ENABLE);
    assign paddr     = addr_r;
    assign pwrite    = write_r;
    assign hrdata    = ((state == ST_ENABLE) && !write_r) ? prdata : '0;
    assign hresp     = HRESP_OKAY;

endmodule
